// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
// Optional build macro AXI4_LITE_REG_ADDR_CHECK_EN (used by the top) enables range checking.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_BYTES  = MAX_DATA_W / 8;

  // Byte-wise merge: take new_val bytes where strb is set, keep old_val elsewhere.
  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_val,
    input logic [MAX_DATA_W-1:0] new_val,
    input logic [MAX_BYTES-1:0]  strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_val;
    for (int k = 0; k < int'(MAX_BYTES); k++) begin
      if (strb[k]) res[k*8 +: 8] = new_val[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Register storage with byte-strobe merge, per-register write pulses and
// an unregistered read mux.
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [$clog2(NUM_REGS)-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/8-1:0]          wr_strb,
  input  logic [$clog2(NUM_REGS)-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0]            rd_data_c,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_q,
  output logic [NUM_REGS-1:0]              reg_wr_pulse
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (wr_en) begin
        regs[wr_idx] <= DATA_WIDTH'(strb_merge(MAX_DATA_W'(regs[wr_idx]),
                                               MAX_DATA_W'(wr_data),
                                               MAX_BYTES'(wr_strb)));
        reg_wr_pulse[wr_idx] <= 1'b1;
      end
    end
  end

  assign rd_data_c = regs[rd_idx];

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave terminating write/read channels into a register bank.
// Define AXI4_LITE_REG_ADDR_CHECK_EN to reject addresses beyond the bank with DECERR.
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [2:0]                     s_awprot,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic [2:0]                     s_arprot,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int unsigned BYTES    = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(BYTES);
  localparam int unsigned IDX_W    = $clog2(NUM_REGS);

  wr_state_t             w_state;
  rd_state_t             r_state;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [BYTES-1:0]      w_strb_q;

  logic                  aw_hs_c, w_hs_c, ar_hs_c, commit_c, wr_en_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c, rd_data_c;
  logic [BYTES-1:0]      wr_strb_c;
  logic                  aw_in_range_c, ar_in_range_c;

  assign aw_hs_c = s_awvalid & s_awready;
  assign w_hs_c  = s_wvalid & s_wready;
  assign ar_hs_c = s_arvalid & s_arready;

  // A commit happens on whichever handshake completes the AW/W pair.
  assign commit_c = ((w_state == W_IDLE)    & aw_hs_c & w_hs_c) |
                    ((w_state == W_HAVE_AW) & w_hs_c) |
                    ((w_state == W_HAVE_W)  & aw_hs_c);

  assign wr_addr_c = (w_state == W_HAVE_AW) ? aw_addr_q : s_awaddr;
  assign wr_data_c = (w_state == W_HAVE_W)  ? w_data_q  : s_wdata;
  assign wr_strb_c = (w_state == W_HAVE_W)  ? w_strb_q  : s_wstrb;

`ifdef AXI4_LITE_REG_ADDR_CHECK_EN
  assign aw_in_range_c = (wr_addr_c[ADDR_WIDTH-1:ADDR_LSB+IDX_W] == '0);
  assign ar_in_range_c = (s_araddr[ADDR_WIDTH-1:ADDR_LSB+IDX_W] == '0);
`else
  assign aw_in_range_c = 1'b1;
  assign ar_in_range_c = 1'b1;
`endif

  assign wr_en_c = commit_c & aw_in_range_c;

  // Write channel FSM: collects AW and W in either order, then holds B until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state   <= W_IDLE;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_awready <= 1'b1;
          s_wready  <= 1'b1;
          if (commit_c) begin
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b1;
            s_bresp   <= aw_in_range_c ? OKAY : DECERR;
            w_state   <= W_RESP;
          end else if (aw_hs_c) begin
            aw_addr_q <= s_awaddr;
            s_awready <= 1'b0;
            w_state   <= W_HAVE_AW;
          end else if (w_hs_c) begin
            w_data_q  <= s_wdata;
            w_strb_q  <= s_wstrb;
            s_wready  <= 1'b0;
            w_state   <= W_HAVE_W;
          end
        end
        W_HAVE_AW, W_HAVE_W: begin
          if (commit_c) begin
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b1;
            s_bresp   <= aw_in_range_c ? OKAY : DECERR;
            w_state   <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_bresp   <= OKAY;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: data is sampled from storage before any same-edge commit lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_arready <= 1'b1;
          if (ar_hs_c) begin
            s_arready <= 1'b0;
            s_rvalid  <= 1'b1;
            s_rdata   <= ar_in_range_c ? rd_data_c : '0;
            s_rresp   <= ar_in_range_c ? OKAY : DECERR;
            r_state   <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= OKAY;
            s_arready <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi4_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_bank (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en_c),
    .wr_idx       (wr_addr_c[ADDR_LSB +: IDX_W]),
    .wr_data      (wr_data_c),
    .wr_strb      (wr_strb_c),
    .rd_idx       (s_araddr[ADDR_LSB +: IDX_W]),
    .rd_data_c    (rd_data_c),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse)
  );

  // Protection bits and address bits outside the decoded field are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{s_awprot, s_arprot, s_awaddr, s_araddr, aw_addr_q, wr_addr_c};

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave with hand-computed expectations.
module tb_axi4_lite_reg_slave;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  s_awaddr = '0;
  logic [2:0]   s_awprot = '0;
  logic         s_awvalid = 1'b0;
  logic         s_awready;
  logic [31:0]  s_wdata = '0;
  logic [3:0]   s_wstrb = '0;
  logic         s_wvalid = 1'b0;
  logic         s_wready;
  logic [1:0]   s_bresp;
  logic         s_bvalid;
  logic         s_bready = 1'b0;
  logic [31:0]  s_araddr = '0;
  logic [2:0]   s_arprot = '0;
  logic         s_arvalid = 1'b0;
  logic         s_arready;
  logic [31:0]  s_rdata;
  logic [1:0]   s_rresp;
  logic         s_rvalid;
  logic         s_rready = 1'b0;
  logic [511:0] reg_q;
  logic [15:0]  reg_wr_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  axi4_lite_reg_slave dut (
    .clock        (clock),
    .reset        (reset),
    .s_awaddr     (s_awaddr),
    .s_awprot     (s_awprot),
    .s_awvalid    (s_awvalid),
    .s_awready    (s_awready),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_wvalid     (s_wvalid),
    .s_wready     (s_wready),
    .s_bresp      (s_bresp),
    .s_bvalid     (s_bvalid),
    .s_bready     (s_bready),
    .s_araddr     (s_araddr),
    .s_arprot     (s_arprot),
    .s_arvalid    (s_arvalid),
    .s_arready    (s_arready),
    .s_rdata      (s_rdata),
    .s_rresp      (s_rresp),
    .s_rvalid     (s_rvalid),
    .s_rready     (s_rready),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rq(input int i);
    return 64'(reg_q[i*32 +: 32]);
  endfunction

  task automatic drive_aw(input logic [31:0] a);
    s_awaddr  = a;
    s_awvalid = 1'b1;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    s_wdata  = d;
    s_wstrb  = s;
    s_wvalid = 1'b1;
  endtask

  task automatic drop_wr();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
  endtask

  initial begin
    // Reset held three cycles
    tick(); tick(); tick();
    chk("rst_awready", 64'(s_awready), 64'h0);
    chk("rst_wready",  64'(s_wready),  64'h0);
    chk("rst_arready", 64'(s_arready), 64'h0);
    chk("rst_bvalid",  64'(s_bvalid),  64'h0);
    chk("rst_rvalid",  64'(s_rvalid),  64'h0);
    chk("rst_rdata",   64'(s_rdata),   64'h0);
    chk("rst_pulse",   64'(reg_wr_pulse), 64'h0);
    chk("rst_regs_nz", 64'(reg_q != '0), 64'h0);
    reset = 1'b0;
    tick();
    chk("rel_awready", 64'(s_awready), 64'h1);
    chk("rel_wready",  64'(s_wready),  64'h1);
    chk("rel_arready", 64'(s_arready), 64'h1);

    // AW+W together to 0x08
    s_bready = 1'b1;
    s_rready = 1'b1;
    drive_aw(32'h08); drive_w(32'hDEADBEEF, 4'hF);
    tick();
    drop_wr();
    chk("t2_bvalid",  64'(s_bvalid), 64'h1);
    chk("t2_bresp",   64'(s_bresp),  64'h0);
    chk("t2_reg2",    rq(2),         64'hDEADBEEF);
    chk("t2_pulse",   64'(reg_wr_pulse), 64'h0004);
    chk("t2_awready", 64'(s_awready), 64'h0);
    tick();
    chk("t2_bvalid_clr", 64'(s_bvalid), 64'h0);
    chk("t2_pulse_clr",  64'(reg_wr_pulse), 64'h0);
    chk("t2_awready_up", 64'(s_awready), 64'h1);

    // Preload reg1, then W first and AW three cycles later
    drive_aw(32'h04); drive_w(32'h12345678, 4'hF);
    tick(); drop_wr(); tick();
    chk("t3_pre_reg1", rq(1), 64'h12345678);
    drive_w(32'h000000AA, 4'h1);
    tick();
    s_wvalid = 1'b0;
    chk("t3_wready_lo", 64'(s_wready),  64'h0);
    chk("t3_aw_rdy",    64'(s_awready), 64'h1);
    chk("t3_no_b",      64'(s_bvalid),  64'h0);
    tick(); tick();
    drive_aw(32'h04);
    tick();
    s_awvalid = 1'b0;
    chk("t3_bvalid", 64'(s_bvalid), 64'h1);
    chk("t3_reg1",   rq(1),         64'h123456AA);
    chk("t3_pulse",  64'(reg_wr_pulse), 64'h0002);
    tick();
    chk("t3_bvalid_clr", 64'(s_bvalid), 64'h0);
    tick();
    chk("t3_single_b", 64'(s_bvalid), 64'h0);

    // AW first, partial strobe W afterwards
    drive_aw(32'h14);
    tick();
    s_awvalid = 1'b0;
    chk("aw1_awready", 64'(s_awready), 64'h0);
    chk("aw1_wready",  64'(s_wready),  64'h1);
    drive_w(32'hFFFFA5A5, 4'h3);
    tick();
    s_wvalid = 1'b0;
    chk("aw1_reg5",   rq(5), 64'h0000A5A5);
    chk("aw1_bvalid", 64'(s_bvalid), 64'h1);
    tick();

    // B backpressure: pending AW/W must wait for the B handshake
    s_bready = 1'b0;
    drive_aw(32'h0C); drive_w(32'hCAFEF00D, 4'hF);
    tick();
    chk("t4_reg3",   rq(3), 64'hCAFEF00D);
    chk("t4_bvalid", 64'(s_bvalid), 64'h1);
    drive_aw(32'h10); drive_w(32'h00000077, 4'hF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_bvalid",  64'(s_bvalid),  64'h1);
      chk("t4_hold_bresp",   64'(s_bresp),   64'h0);
      chk("t4_hold_awready", 64'(s_awready), 64'h0);
      chk("t4_hold_reg4",    rq(4),          64'h0);
    end
    s_bready = 1'b1;
    tick();
    chk("t4_b_done",  64'(s_bvalid),  64'h0);
    chk("t4_aw_back", 64'(s_awready), 64'h1);
    chk("t4_reg4_wait", rq(4), 64'h0);
    tick();
    drop_wr();
    chk("t4_new_b",  64'(s_bvalid), 64'h1);
    chk("t4_reg4",   rq(4),         64'h77);
    tick();
    chk("t4_b_clr",  64'(s_bvalid), 64'h0);

    // Read 0x08 with R backpressure
    s_rready  = 1'b0;
    s_araddr  = 32'h08;
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    chk("t5_rvalid",  64'(s_rvalid),  64'h1);
    chk("t5_rdata",   64'(s_rdata),   64'hDEADBEEF);
    chk("t5_rresp",   64'(s_rresp),   64'h0);
    chk("t5_arready", 64'(s_arready), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_hold_rvalid", 64'(s_rvalid), 64'h1);
      chk("t5_hold_rdata",  64'(s_rdata),  64'hDEADBEEF);
    end
    s_rready = 1'b1;
    tick();
    chk("t5_r_done",  64'(s_rvalid),  64'h0);
    chk("t5_ar_back", 64'(s_arready), 64'h1);

    // Read and write to reg3 on the same edge: old value returned
    s_araddr  = 32'h0C;
    s_arvalid = 1'b1;
    drive_aw(32'h0C); drive_w(32'h00000001, 4'hF);
    tick();
    s_arvalid = 1'b0;
    drop_wr();
    chk("t5_coll_rdata", 64'(s_rdata), 64'hCAFEF00D);
    chk("t5_coll_reg3",  rq(3),        64'h1);
    chk("t5_coll_b",     64'(s_bvalid), 64'h1);
    tick();
    chk("t5_coll_r_clr", 64'(s_rvalid), 64'h0);
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    chk("t5_reread", 64'(s_rdata), 64'h1);
    tick();

    // Address 0x100: beyond the bank
    drive_aw(32'h100); drive_w(32'h0BADF00D, 4'hF);
    tick();
    drop_wr();
`ifdef AXI4_LITE_REG_ADDR_CHECK_EN
    chk("t6_bresp", 64'(s_bresp), 64'h3);
    chk("t6_reg0",  rq(0),        64'h0);
    chk("t6_pulse", 64'(reg_wr_pulse), 64'h0);
`else
    chk("t6_bresp", 64'(s_bresp), 64'h0);
    chk("t6_reg0",  rq(0),        64'h0BADF00D);
    chk("t6_pulse", 64'(reg_wr_pulse), 64'h0001);
`endif
    tick();
    s_araddr  = 32'h100;
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
`ifdef AXI4_LITE_REG_ADDR_CHECK_EN
    chk("t6_rdata", 64'(s_rdata), 64'h0);
    chk("t6_rresp", 64'(s_rresp), 64'h3);
`else
    chk("t6_rdata", 64'(s_rdata), 64'h0BADF00D);
    chk("t6_rresp", 64'(s_rresp), 64'h0);
`endif
    tick();

    // Reset mid-transaction drops the latched AW
    drive_aw(32'h18);
    tick();
    s_awvalid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_bvalid",  64'(s_bvalid),  64'h0);
    chk("mr_awready", 64'(s_awready), 64'h0);
    chk("mr_regs_nz", 64'(reg_q != '0), 64'h0);
    tick();
    chk("mr_awready_up", 64'(s_awready), 64'h1);
    chk("mr_wready_up",  64'(s_wready),  64'h1);
    drive_w(32'h00000099, 4'hF);
    tick();
    s_wvalid = 1'b0;
    chk("mr_no_b",  64'(s_bvalid), 64'h0);
    chk("mr_wlo",   64'(s_wready), 64'h0);
    chk("mr_reg6",  rq(6),         64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
